// File: rtl/decoder_sweep_checker.sv
// Self-test sweep around the 2x4 decoder implementing F = (AB' + A'B)(C + D').
// Optional disabled-enable pass is built when SWEEP_DISABLE_CHECK_EN is defined.
module decoder_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED_TT   = 16'h0DD0,
  parameter logic        DISABLED_F    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f_in,
  output logic        dec_en,
  output logic [3:0]  abcd_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] truth_table,
  output logic [5:0]  mismatch_cnt,
  output logic [4:0]  first_fail_idx
);

`ifdef SWEEP_DISABLE_CHECK_EN
  typedef enum logic [2:0] {StIdle, StSettle, StSample, StDone, StDisSettle, StDisSample} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;
`endif

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dec_en_q, dec_en_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] tt_q, tt_d;
  logic [5:0]  mm_q, mm_d;
  logic [4:0]  ff_q, ff_d;
  logic        miss;
  logic [4:0]  fail_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= 4'd0;
      cnt_q    <= 4'd0;
      dec_en_q <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      tt_q     <= 16'd0;
      mm_q     <= 6'd0;
      ff_q     <= 5'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      dec_en_q <= dec_en_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      tt_q     <= tt_d;
      mm_q     <= mm_d;
      ff_q     <= ff_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    dec_en_d  = dec_en_q;
    done_d    = done_q;
    pass_d    = pass_q;
    tt_d      = tt_q;
    mm_d      = mm_q;
    ff_d      = ff_q;
    miss      = 1'b0;
    fail_code = 5'd0;

    case (state_q)
      StIdle, StDone: begin
        // The first DONE cycle publishes done/pass; start is still ignored there.
        if (state_q == StDone && !done_q) begin
          done_d = 1'b1;
          pass_d = (mm_q == 6'd0);
        end else if (start) begin
          tt_d     = 16'd0;
          mm_d     = 6'd0;
          ff_d     = 5'd0;
          pass_d   = 1'b0;
          done_d   = 1'b0;
          idx_d    = 4'd0;
          cnt_d    = 4'd0;
          dec_en_d = 1'b1;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == 4'(SETTLE_CYCLES - 1)) begin
          cnt_d   = 4'd0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSample: begin
        tt_d[idx_q] = f_in;
        miss        = (f_in != EXPECTED_TT[idx_q]);
        fail_code   = {1'b0, idx_q};
        if (idx_q == 4'd15) begin
          idx_d    = 4'd0;
          dec_en_d = 1'b0;
`ifdef SWEEP_DISABLE_CHECK_EN
          state_d  = StDisSettle;
`else
          state_d  = StDone;
`endif
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = StSettle;
        end
      end
`ifdef SWEEP_DISABLE_CHECK_EN
      StDisSettle: begin
        if (cnt_q == 4'(SETTLE_CYCLES - 1)) begin
          cnt_d   = 4'd0;
          state_d = StDisSample;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDisSample: begin
        miss      = (f_in != DISABLED_F);
        fail_code = {1'b1, idx_q};
        if (idx_q == 4'd15) begin
          idx_d   = 4'd0;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = StDisSettle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (miss) begin
      if (mm_q == 6'd0) ff_d = fail_code;
      if (mm_q != 6'd32) mm_d = mm_q + 6'd1;
    end
  end

  assign dec_en         = dec_en_q;
  assign abcd_out       = idx_q;
  assign busy           = (state_q != StIdle) && !done_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign truth_table    = tt_q;
  assign mismatch_cnt   = mm_q;
  assign first_fail_idx = ff_q;

endmodule
